// File: rtl/priority_arb_n_v.sv
// Registered N-line priority/round-robin arbiter. A grant is offered on a
// valid/ready handshake and held stable until the consumer accepts it.
module priority_arb_n_v #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_mode,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_grant_idx,
    output logic [N-1:0] o_grant_oh,
    output logic         o_any_req
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   ptr_r;
    logic [W-1:0]   ptr_inc_s;
    logic [W-1:0]   ptr_eff_s;
    logic [W-1:0]   arb_idx_s;
    logic [N-1:0]   arb_oh_s;
    logic [W-1:0]   cand_idx_s;
    logic           found_s;
    logic           hit_s;
    int             cand_s;
    logic           any_req_s;
    logic           load_s;
    logic           accept_s;
    logic           valid_r;
    logic [W-1:0]   idx_r;
    logic [N-1:0]   oh_r;

    assign any_req_s = |i_req;

    // Successor of the granted index, wrapping mod N rather than mod 2^W so
    // unused codes of a non-power-of-2 N can never be reached.
    assign ptr_inc_s = (idx_r == W'(N - 1)) ? {W{1'b0}} : (idx_r + {{(W-1){1'b0}}, 1'b1});

    // An accept and a re-arbitration share one edge, so the search must start
    // from the pointer value that the accept is about to write.
    assign ptr_eff_s = accept_s ? ptr_inc_s : ptr_r;

    // Arbitration: lowest set line in fixed mode, first set line at or above
    // the pointer (wrapping) in round-robin mode.
    always_comb begin
        arb_idx_s  = {W{1'b0}};
        found_s    = 1'b0;
        hit_s      = 1'b0;
        cand_s     = 0;
        cand_idx_s = {W{1'b0}};
        if (!i_mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                arb_idx_s = i_req[i] ? W'(i) : arb_idx_s;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                cand_s     = int'(ptr_eff_s) + k;
                cand_s     = (cand_s >= N) ? (cand_s - N) : cand_s;
                cand_idx_s = W'(cand_s);
                hit_s      = !found_s && i_req[cand_idx_s];
                arb_idx_s  = hit_s ? cand_idx_s : arb_idx_s;
                found_s    = found_s | hit_s;
            end
        end
    end

    // One-hot form of the arbitration result.
    always_comb begin
        arb_oh_s            = {N{1'b0}};
        arb_oh_s[arb_idx_s] = 1'b1;
    end

    // Next-state and handshake control.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    accept_s = 1'b1;
                    if (any_req_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer and presented-grant registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            ptr_r   <= {W{1'b0}};
            valid_r <= 1'b0;
            idx_r   <= {W{1'b0}};
            oh_r    <= {N{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ptr_r <= ptr_inc_s;
            end
            if (load_s) begin
                valid_r <= 1'b1;
                idx_r   <= arb_idx_s;
                oh_r    <= arb_oh_s;
            end else if (state_nxt_s == IDLE) begin
                valid_r <= 1'b0;
                idx_r   <= {W{1'b0}};
                oh_r    <= {N{1'b0}};
            end
        end
    end

    assign o_valid     = valid_r;
    assign o_grant_idx = idx_r;
    assign o_grant_oh  = oh_r;
    assign o_any_req   = any_req_s;

endmodule

// File: tb/tb_priority_arb_n_v.sv
// Scoreboard bench for priority_arb_n_v: an 8-line and a 5-line instance,
// directed stimulus pushes expected grants, monitors pop on acceptance.
module tb_priority_arb_n_v;

    logic       clk;
    logic       rst_n;
    logic [7:0] req8;
    logic       mode8;
    logic       ready8;
    logic       valid8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic       any8;
    logic [4:0] req5;
    logic       mode5;
    logic       ready5;
    logic       valid5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic       any5;

    int n_tests = 0;
    int n_fail  = 0;
    int q8[$];
    int q5[$];

    priority_arb_n_v #(.N(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req8), .i_mode(mode8), .i_ready(ready8),
        .o_valid(valid8), .o_grant_idx(idx8), .o_grant_oh(oh8), .o_any_req(any8)
    );

    priority_arb_n_v #(.N(5)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req5), .i_mode(mode5), .i_ready(ready5),
        .o_valid(valid5), .o_grant_idx(idx5), .o_grant_oh(oh5), .o_any_req(any5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-line instance
    always @(negedge clk) begin
        int         exp_idx;
        logic [7:0] exp_oh;
        if (rst_n) begin
            if (valid8) begin
                if (q8.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant8: got idx %0d expected no grant", idx8);
                end else begin
                    exp_idx = q8[0];
                    exp_oh  = 8'b0000_0001 << exp_idx;
                    check("grant_idx8", idx8, exp_idx);
                    check("grant_oh8", oh8, exp_oh);
                    if (ready8) void'(q8.pop_front());
                end
            end else begin
                check("idle_oh8", oh8, 0);
            end
        end
    end

    // Monitor for the 5-line instance
    always @(negedge clk) begin
        int         exp_idx;
        logic [4:0] exp_oh;
        if (rst_n) begin
            if (valid5) begin
                check("idx5_in_range", (idx5 < 3'd5) ? 1 : 0, 1);
                if (q5.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant5: got idx %0d expected no grant", idx5);
                end else begin
                    exp_idx = q5[0];
                    exp_oh  = 5'b0_0001 << exp_idx;
                    check("grant_idx5", idx5, exp_idx);
                    check("grant_oh5", oh5, exp_oh);
                    if (ready5) void'(q5.pop_front());
                end
            end else begin
                check("idle_oh5", oh5, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        req8   = 8'h00;
        mode8  = 1'b0;
        ready8 = 1'b0;
        req5   = 5'b0_0000;
        mode5  = 1'b1;
        ready5 = 1'b0;
        step(2);
        check("rst_valid8", valid8, 0);
        check("rst_oh8", oh8, 0);
        check("rst_idx8", idx8, 0);
        check("rst_valid5", valid5, 0);
        check("any_req_zero", any8, 0);

        // Fixed priority: lowest set line of 1010_0100 is 2
        rst_n  = 1'b1;
        req8   = 8'b1010_0100;
        ready8 = 1'b1;
        repeat (4) q8.push_back(2);
        #1;
        check("any_req_one", any8, 1);
        step(4);

        // Hold under backpressure: grant 5 held while requests change
        req8 = 8'h20;
        q8.push_back(5);
        step(1);
        ready8 = 1'b0;
        req8   = 8'h01;
        step(3);

        // Accept 5 sets ptr=6; round-robin on 0000_1001 gives 0, 3, 0
        ready8 = 1'b1;
        req8   = 8'b0000_1001;
        mode8  = 1'b1;
        q8.push_back(0);
        q8.push_back(3);
        q8.push_back(0);
        step(3);

        // Drain at accept
        req8 = 8'h00;
        step(1);
        check("drain_valid8", valid8, 0);
        check("drain_oh8", oh8, 0);

        // Present a grant, then reset mid-handshake
        req8   = 8'h80;
        ready8 = 1'b0;
        q8.push_back(7);
        step(1);
        rst_n = 1'b0;
        step(1);
        q8.delete();
        check("midrst_valid8", valid8, 0);
        check("midrst_oh8", oh8, 0);
        check("midrst_idx8", idx8, 0);

        // Round-robin fairness from ptr=0 after reset
        rst_n  = 1'b1;
        req8   = 8'hFF;
        ready8 = 1'b1;
        for (int i = 0; i < 10; i++) q8.push_back(i % 8);
        step(10);
        req8 = 8'h00;
        step(2);
        check("q8_drained", q8.size(), 0);
        check("end_valid8", valid8, 0);

        // Non-power-of-2: lines 0 and 4 alternate
        req5   = 5'b1_0001;
        ready5 = 1'b1;
        q5.push_back(0);
        q5.push_back(4);
        q5.push_back(0);
        q5.push_back(4);
        step(4);
        req5 = 5'b0_0000;
        step(2);
        check("q5_drained", q5.size(), 0);
        check("end_valid5", valid5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arb_n_v.md
Name: priority_arb_n_v

Overview:
- Parametrised, registered successor to the 4:2 combinational priority encoder.
- Encodes N request lines into a binary grant index plus a one-hot grant.
- Mode input selects fixed priority (line 0 highest) or round-robin.
- Grant is presented on a valid/ready handshake and held stable until accepted. Sits between request sources (interrupt lines, bus masters) and a single shared consumer.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), grant index width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req  in  N  request lines, level sensitive, not latched.
- i_mode  in  1  0 = fixed priority (bit 0 highest); 1 = round-robin.
- i_ready  in  1  consumer accepts the presented grant.
- o_valid  out  1  a grant is presented.
- o_grant_idx  out  W  binary index of the granted line.
- o_grant_oh  out  N  one-hot grant; all zero when o_valid=0.
- o_any_req  out  1  combinational OR of i_req (same as the original o_valid equation).

Behaviour:
- Reset: when i_rst_n=0 at a rising edge, the following clear:
  - o_valid=0, o_grant_idx=0, o_grant_oh=0
  - round-robin pointer ptr=0
  - state=IDLE
  Reset mid-handshake drops the held grant with no acceptance.
- State machine has two states, IDLE and HOLD.
  - IDLE: if |i_req, register the arbitration result, set o_valid=1, go to HOLD. Otherwise stay in IDLE with o_valid=0.
  - HOLD, i_ready=0: o_valid, o_grant_idx and o_grant_oh hold stable, even if i_req changes or drops. i_mode changes are ignored until the next arbitration.
  - HOLD, i_ready=1 (accept): re-arbitrate on the current i_req in the same edge. If |i_req, present the new grant next cycle and stay in HOLD (back-to-back, one grant per cycle). Otherwise go to IDLE with o_valid=0.
- Latency: 1 cycle from a request asserted in IDLE to o_valid=1. Sustained throughput is 1 grant per cycle while i_ready=1.
- Fixed mode: grant the lowest set index of i_req.
- Round-robin mode:
  - Grant the first set index searching upward from ptr, wrapping from N-1 to 0.
  - On each accept, ptr <= (granted idx + 1) mod N. When idx = N-1, ptr wraps to 0.
  - ptr is updated only on accept, never on presentation.
- ptr in fixed mode: ptr is also updated on accepts in fixed mode, so switching to round-robin continues from the last accepted grant.
- Invariant: o_grant_oh == (1 << o_grant_idx) whenever o_valid=1.
- Arithmetic:
  - Index arithmetic is mod N, not mod 2^W. For non-power-of-2 N, the value N must never appear on o_grant_idx or ptr.
  - Unused index codes are unreachable.
- All-zero requests: no grant; o_valid stays 0. o_any_req=0.

Test Plan:
- Reset then fixed priority:
  - Stimulus: N=8, i_mode=0, i_rst_n low 2 cycles, then i_req=8'b1010_0100, i_ready=1.
  - Required: during reset o_valid=0. One cycle after i_req, o_valid=1, idx=2, oh=8'h04. While i_req is unchanged, every grant is idx=2.
- Hold under backpressure:
  - Stimulus: i_ready=0, grant idx=5 presented; change i_req to 8'h01 for 3 cycles, then i_ready=1.
  - Required: idx stays 5 for all 3 cycles, accepted on the ready cycle. Next grant is idx=0.
- Round-robin fairness:
  - Stimulus: i_mode=1, i_req=8'hFF held, i_ready=1 for 10 cycles.
  - Required: idx sequence 0,1,2,...,7,0,1; ptr wraps 7 to 0.
- Round-robin skip and wrap:
  - Stimulus: i_mode=1, ptr=6, i_req=8'b0000_1001.
  - Required: grant idx=0, then idx=3, then idx=0.
- Non-power-of-2:
  - Stimulus: N=5, i_mode=1, i_req=5'b10001, i_ready=1.
  - Required: alternating idx 0,4,0,4. Index 5..7 is never produced.
- Drain and mid-operation reset:
  - Stimulus 1: i_req drops to 0 at an accept. Required: o_valid=0 next cycle, state IDLE.
  - Stimulus 2: i_rst_n=0 while in HOLD. Required: o_valid=0 and oh=0 after the edge; first round-robin grant after reset starts from ptr=0.
